// File: rtl/dual_port_be_memory_if.sv
// Request/response bundle between a client and dual_port_be_memory.
// Master drives the write and read requests; slave returns status and read data.
interface dual_port_be_memory_if #(
    parameter int WORDS      = 10,
    parameter int DATA_WIDTH = 32
);
    logic                      wr_en_i;
    logic [WORDS-1:0]          wr_addr_i;
    logic [DATA_WIDTH-1:0]     wr_data_i;
    logic [DATA_WIDTH/8-1:0]   wr_be_i;
    logic                      rd_en_i;
    logic [WORDS-1:0]          rd_addr_i;
    logic                      ready_o;
    logic                      rd_valid_o;
    logic [DATA_WIDTH-1:0]     rd_data_o;
    logic                      clearing_o;

    modport master (
        output wr_en_i, wr_addr_i, wr_data_i, wr_be_i, rd_en_i, rd_addr_i,
        input  ready_o, rd_valid_o, rd_data_o, clearing_o
    );

    modport slave (
        input  wr_en_i, wr_addr_i, wr_data_i, wr_be_i, rd_en_i, rd_addr_i,
        output ready_o, rd_valid_o, rd_data_o, clearing_o
    );
endinterface

// File: rtl/dual_port_be_memory.sv
// Byte-lane-writable dual-port RAM (one write, one read port) with 1- or 2-cycle read latency,
// selectable read-during-write result and an optional post-reset zeroing sweep.
module dual_port_be_memory #(
    parameter int WORDS          = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int READ_LATENCY   = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    dual_port_be_memory_if.slave  bus
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** WORDS;

    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    localparam logic [WORDS:0] LAST_CNT = {1'b0, {WORDS{1'b1}}};

    generate
        if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
            $error("dual_port_be_memory: DATA_WIDTH must be a multiple of 8");
        end
        if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
            $error("dual_port_be_memory: READ_LATENCY must be 1 or 2");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [1:0]            state_q, state_d;
    logic [WORDS:0]        cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic                  clearing_q, clearing_d;
    logic                  clear_we_s;
    logic                  wr_acc_s;
    logic                  rd_acc_s;
    logic                  rdw_hit_s;
    logic [DATA_WIDTH-1:0] mem_word_s;
    logic [DATA_WIDTH-1:0] rd_word_s;
    logic                  s1_valid_q;
    logic [DATA_WIDTH-1:0] s1_data_q;
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;

    assign wr_acc_s = ready_q & bus.wr_en_i;
    assign rd_acc_s = ready_q & bus.rd_en_i;

    // Sequencer: the first edge after release already zeroes word 0, so READY lands after exactly DEPTH edges.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ready_d    = ready_q;
        clearing_d = clearing_q;
        clear_we_s = 1'b0;
        case (state_q)
            ST_RESET: begin
                if (CLEAR_ON_RESET != 0) begin
                    clear_we_s = ~reset_i;
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d    = ST_READY;
                        ready_d    = 1'b1;
                        clearing_d = 1'b0;
                    end else begin
                        state_d    = ST_CLEAR;
                        clearing_d = 1'b1;
                    end
                end else begin
                    state_d = ST_READY;
                    ready_d = 1'b1;
                end
            end
            ST_CLEAR: begin
                clear_we_s = 1'b1;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d    = ST_READY;
                    ready_d    = 1'b1;
                    clearing_d = 1'b0;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d    = ST_RESET;
                cnt_d      = '0;
                ready_d    = 1'b0;
                clearing_d = 1'b0;
            end
        endcase
    end

    // Read-port word; in new-data mode the written lanes bypass the array on an address collision.
    always_comb begin
        mem_word_s = mem_q[bus.rd_addr_i];
        rdw_hit_s  = (RDW_MODE == 1) && wr_acc_s && (bus.wr_addr_i == bus.rd_addr_i);
        rd_word_s  = mem_word_s;
        for (int i = 0; i < LANES; i++) begin
            rd_word_s[8*i +: 8] = (rdw_hit_s && bus.wr_be_i[i]) ? bus.wr_data_i[8*i +: 8]
                                                                : mem_word_s[8*i +: 8];
        end
    end

    // Array storage: not reset, written by the clear sweep or by accepted byte-lane writes.
    always_ff @(posedge clk_i) begin
        if (clear_we_s) begin
            mem_q[cnt_q[WORDS-1:0]] <= '0;
        end else if (wr_acc_s) begin
            for (int i = 0; i < LANES; i++) begin
                if (bus.wr_be_i[i]) begin
                    mem_q[bus.wr_addr_i][8*i +: 8] <= bus.wr_data_i[8*i +: 8];
                end
            end
        end
    end

    // Control state and read pipeline; reset flushes any read in flight.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_RESET;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            clearing_q <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            clearing_q <= clearing_d;
            s1_valid_q <= rd_acc_s;
            if (rd_acc_s) begin
                s1_data_q <= rd_word_s;
            end
            if (READ_LATENCY == 1) begin
                rd_valid_q <= rd_acc_s;
                if (rd_acc_s) begin
                    rd_data_q <= rd_word_s;
                end
            end else begin
                rd_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    rd_data_q <= s1_data_q;
                end
            end
        end
    end

    assign bus.ready_o    = ready_q;
    assign bus.clearing_o = clearing_q;
    assign bus.rd_valid_o = rd_valid_q;
    assign bus.rd_data_o  = rd_data_q;
endmodule

// File: tb/tb_dual_port_be_memory.sv
// Three instances share one stimulus: d0 = latency 1 / old-data, d1 = latency 1 / new-data, d2 = latency 2 / old-data.
module tb_dual_port_be_memory;
    localparam int W  = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en, rd_en;
    logic [W-1:0]  wr_addr, rd_addr;
    logic [DW-1:0] wr_data;
    logic [3:0]    wr_be;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dual_port_be_memory_if #(.WORDS(W), .DATA_WIDTH(DW)) if_a ();
    dual_port_be_memory_if #(.WORDS(W), .DATA_WIDTH(DW)) if_b ();
    dual_port_be_memory_if #(.WORDS(W), .DATA_WIDTH(DW)) if_c ();

    assign if_a.wr_en_i = wr_en;   assign if_b.wr_en_i = wr_en;   assign if_c.wr_en_i = wr_en;
    assign if_a.wr_addr_i = wr_addr; assign if_b.wr_addr_i = wr_addr; assign if_c.wr_addr_i = wr_addr;
    assign if_a.wr_data_i = wr_data; assign if_b.wr_data_i = wr_data; assign if_c.wr_data_i = wr_data;
    assign if_a.wr_be_i = wr_be;   assign if_b.wr_be_i = wr_be;   assign if_c.wr_be_i = wr_be;
    assign if_a.rd_en_i = rd_en;   assign if_b.rd_en_i = rd_en;   assign if_c.rd_en_i = rd_en;
    assign if_a.rd_addr_i = rd_addr; assign if_b.rd_addr_i = rd_addr; assign if_c.rd_addr_i = rd_addr;

    dual_port_be_memory #(.WORDS(W), .DATA_WIDTH(DW), .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1))
        dut_a (.clk_i(clk), .reset_i(rst), .bus(if_a));
    dual_port_be_memory #(.WORDS(W), .DATA_WIDTH(DW), .READ_LATENCY(1), .RDW_MODE(1), .CLEAR_ON_RESET(1))
        dut_b (.clk_i(clk), .reset_i(rst), .bus(if_b));
    dual_port_be_memory #(.WORDS(W), .DATA_WIDTH(DW), .READ_LATENCY(2), .RDW_MODE(0), .CLEAR_ON_RESET(1))
        dut_c (.clk_i(clk), .reset_i(rst), .bus(if_c));

    logic          rv  [3];
    logic          rdy [3];
    logic          clr [3];
    logic [DW-1:0] rdd [3];

    assign rv[0] = if_a.rd_valid_o; assign rv[1] = if_b.rd_valid_o; assign rv[2] = if_c.rd_valid_o;
    assign rdy[0] = if_a.ready_o;   assign rdy[1] = if_b.ready_o;   assign rdy[2] = if_c.ready_o;
    assign clr[0] = if_a.clearing_o; assign clr[1] = if_b.clearing_o; assign clr[2] = if_c.clearing_o;
    assign rdd[0] = if_a.rd_data_o; assign rdd[1] = if_b.rd_data_o; assign rdd[2] = if_c.rd_data_o;

    typedef struct {
        logic          we;
        logic [W-1:0]  wa;
        logic [DW-1:0] wd;
        logic [3:0]    be;
        logic          re;
        logic [W-1:0]  ra;
        logic [2:0]    ev;
        logic [DW-1:0] ed0;
        logic [DW-1:0] ed1;
        logic [DW-1:0] ed2;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input int d, input logic exp_v, input logic [DW-1:0] exp_d);
        check($sformatf("%s d%0d rd_valid", tag, d), {31'd0, rv[d]}, {31'd0, exp_v});
        check($sformatf("%s d%0d rd_data", tag, d), rdd[d], exp_d);
    endtask

    task automatic chk_status(input string tag, input logic exp_rdy, input logic exp_clr);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s d%0d ready", tag, d), {31'd0, rdy[d]}, {31'd0, exp_rdy});
            check($sformatf("%s d%0d clearing", tag, d), {31'd0, clr[d]}, {31'd0, exp_clr});
        end
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = 4'h0;
        rd_en = 1'b0; rd_addr = '0;
    endtask

    task automatic add(input logic we, input logic [W-1:0] wa, input logic [DW-1:0] wd, input logic [3:0] be,
                       input logic re, input logic [W-1:0] ra, input logic [2:0] ev,
                       input logic [DW-1:0] e0, input logic [DW-1:0] e1, input logic [DW-1:0] e2);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.be = be; v.re = re; v.ra = ra;
        v.ev = ev; v.ed0 = e0; v.ed1 = e1; v.ed2 = e2;
        vecs.push_back(v);
    endtask

    // Called at the negedge of release; optionally with requests already driven (they must be ignored).
    task automatic sweep(input string tag);
        chk_status({tag, " release"}, 1'b0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            if (k < 16) chk_status($sformatf("%s clk%0d", tag, k), 1'b0, 1'b1);
            else        chk_status($sformatf("%s clk%0d", tag, k), 1'b1, 1'b0);
            for (int d = 0; d < 3; d++)
                check($sformatf("%s clk%0d d%0d no pulse", tag, k, d), {31'd0, rv[d]}, 32'd0);
            if (k == 16) idle();
        end
    endtask

    task automatic read_check(input logic [W-1:0] a, input logic [DW-1:0] exp);
        @(negedge clk); rd_en = 1'b1; rd_addr = a;
        @(posedge clk); #1;
        chk_rd($sformatf("rd@%0d e1", a), 0, 1'b1, exp);
        chk_rd($sformatf("rd@%0d e1", a), 1, 1'b1, exp);
        check($sformatf("rd@%0d e1 d2 rd_valid", a), {31'd0, rv[2]}, 32'd0);
        @(negedge clk); rd_en = 1'b0;
        @(posedge clk); #1;
        check($sformatf("rd@%0d e2 d0 rd_valid", a), {31'd0, rv[0]}, 32'd0);
        chk_rd($sformatf("rd@%0d e2", a), 2, 1'b1, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        chk_status("reset", 1'b0, 1'b0);
        for (int d = 0; d < 3; d++) chk_rd("reset", d, 1'b0, 32'h0);

        // First boot, then fill every word with ones so the second sweep has something to erase.
        @(negedge clk); rst = 1'b0;
        for (k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (rdy[0] && rdy[1] && rdy[2]) break;
        end
        check("boot ready", {31'd0, rdy[0] & rdy[1] & rdy[2]}, 32'd1);
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = W'(a); wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
        end
        @(negedge clk); idle();
        read_check(4'd6, 32'hFFFF_FFFF);

        @(negedge clk); rst = 1'b1;
        #1 chk_status("reset2", 1'b0, 1'b0);
        for (int d = 0; d < 3; d++) chk_rd("reset2", d, 1'b0, 32'h0);
        @(negedge clk); rst = 1'b0;
        sweep("clear");
        for (int a = 0; a < 16; a++) read_check(W'(a), 32'h0);

        add(1, 3, 32'h1122_3344, 4'hF, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0);
        add(1, 3, 32'hAABB_CCDD, 4'h5, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0);
        add(1, 3, 32'h9999_9999, 4'h0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0);
        add(0, 0, 32'h0, 4'h0, 1, 3, 3'b011, 32'h11BB_33DD, 32'h11BB_33DD, 32'h0);
        add(0, 0, 32'h0, 4'h0, 0, 0, 3'b100, 32'h11BB_33DD, 32'h11BB_33DD, 32'h11BB_33DD);
        add(0, 0, 32'h0, 4'h0, 0, 0, 3'b000, 32'h11BB_33DD, 32'h11BB_33DD, 32'h11BB_33DD);
        add(1, 5, 32'hDEAD_BEEF, 4'hF, 1, 5, 3'b011, 32'h0, 32'hDEAD_BEEF, 32'h11BB_33DD);
        add(1, 5, 32'h0, 4'hF, 1, 5, 3'b111, 32'hDEAD_BEEF, 32'h0, 32'h0);
        add(1, 5, 32'hDEAD_BEEF, 4'h3, 1, 5, 3'b111, 32'h0, 32'h0000_BEEF, 32'hDEAD_BEEF);
        add(0, 0, 32'h0, 4'h0, 1, 5, 3'b111, 32'h0000_BEEF, 32'h0000_BEEF, 32'h0);
        add(0, 0, 32'h0, 4'h0, 0, 0, 3'b100, 32'h0000_BEEF, 32'h0000_BEEF, 32'h0000_BEEF);
        add(1, 0, 32'h0000_000A, 4'hF, 0, 0, 3'b000, 32'h0000_BEEF, 32'h0000_BEEF, 32'h0000_BEEF);
        add(1, 1, 32'h0000_000B, 4'hF, 0, 0, 3'b000, 32'h0000_BEEF, 32'h0000_BEEF, 32'h0000_BEEF);
        add(1, 2, 32'h0000_000C, 4'hF, 0, 0, 3'b000, 32'h0000_BEEF, 32'h0000_BEEF, 32'h0000_BEEF);
        add(0, 0, 32'h0, 4'h0, 1, 0, 3'b011, 32'hA, 32'hA, 32'h0000_BEEF);
        add(0, 0, 32'h0, 4'h0, 1, 1, 3'b111, 32'hB, 32'hB, 32'hA);
        add(0, 0, 32'h0, 4'h0, 1, 2, 3'b111, 32'hC, 32'hC, 32'hB);
        add(0, 0, 32'h0, 4'h0, 0, 0, 3'b100, 32'hC, 32'hC, 32'hC);
        add(0, 0, 32'h0, 4'h0, 0, 0, 3'b000, 32'hC, 32'hC, 32'hC);
        add(1, 7, 32'h0000_0077, 4'hF, 1, 3, 3'b011, 32'h11BB_33DD, 32'h11BB_33DD, 32'hC);
        add(0, 0, 32'h0, 4'h0, 1, 7, 3'b111, 32'h77, 32'h77, 32'h11BB_33DD);
        add(0, 0, 32'h0, 4'h0, 0, 0, 3'b100, 32'h77, 32'h77, 32'h77);

        foreach (vecs[i]) begin
            @(negedge clk);
            wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd; wr_be = vecs[i].be;
            rd_en = vecs[i].re; rd_addr = vecs[i].ra;
            @(posedge clk); #1;
            chk_rd($sformatf("vec%0d", i), 0, vecs[i].ev[0], vecs[i].ed0);
            chk_rd($sformatf("vec%0d", i), 1, vecs[i].ev[1], vecs[i].ed1);
            chk_rd($sformatf("vec%0d", i), 2, vecs[i].ev[2], vecs[i].ed2);
        end
        @(negedge clk); idle();

        // Reset during clear cycle 7 with a read held; nothing may come out of it.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; rd_en = 1'b1; rd_addr = 4'd3;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++)
                check($sformatf("held clk%0d d%0d no pulse", c, d), {31'd0, rv[d]}, 32'd0);
        end
        #2 rst = 1'b1;
        #1 chk_status("abort", 1'b0, 1'b0);
        for (int d = 0; d < 3; d++) chk_rd("abort", d, 1'b0, 32'h0);

        // Restarted sweep with write/read of word 9 presented while not ready.
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'h0000_0055; wr_be = 4'hF;
        rd_en = 1'b1; rd_addr = 4'd9;
        rst = 1'b0;
        sweep("restart");
        read_check(4'd9, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
